mul_add_reconstructor: RTL and testbench

Sequential shift-add multiply-accumulate unit computing PRODUCT = MCAND × MPLIER + ADDEND. It is the inverse of the division datapath: it rebuilds a dividend from quotient, divisor and remainder. It sits beside the divider as a self-check and round-trip engine. It uses the same level-sensitive Start / one-cycle Finish handshake as the divider, so one controller can drive both.

---
 rtl/mul_add_pkg.sv | 18 +
 rtl/mul_add_reconstructor_shift_add_datapath.sv | 57 +++++
 rtl/mul_add_reconstructor.sv | 88 ++++++++
 tb/tb_mul_add_reconstructor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mul_add_pkg.sv
// Shared types and constants for the shift-add multiply-accumulate unit.
package mul_add_pkg;

  localparam int N_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADDR = 2'd2,
    DONE = 2'd3
  } state_e;

  // Iteration counter width: ceil(log2 n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_add_reconstructor_shift_add_datapath.sv
// P/M/R registers with the (N+1)-bit adder and right shifter; PRODUCT register.
module shift_add_datapath #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           finalize,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  input  logic [N-1:0]   addend,
  output logic [2*N-1:0] product
);

  logic [2*N:0]   p_q, p_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   r_q, r_d;
  logic [2*N-1:0] product_q, product_d;
  logic [N:0]     h_next;

  always_comb begin
    p_d       = p_q;
    m_d       = m_q;
    r_d       = r_q;
    product_d = product_q;
    // Conditional add into the high half, driven by the current multiplier LSB.
    h_next    = p_q[2*N:N] + (p_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
    if (load) begin
      m_d = mcand;
      r_d = addend;
      p_d = {{(N+1){1'b0}}, mplier};
    end else if (step) begin
      p_d = {h_next, p_q[N-1:0]} >> 1;
    end
    if (finalize) begin
      product_d = p_q[2*N-1:0] + {{N{1'b0}}, r_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      m_q       <= '0;
      r_q       <= '0;
      product_q <= '0;
    end else begin
      p_q       <= p_d;
      m_q       <= m_d;
      r_q       <= r_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/mul_add_reconstructor.sv
// Sequential PRODUCT = MCAND * MPLIER + ADDEND with a Start / Finish handshake.
module mul_add_reconstructor
  import mul_add_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  input  logic [N-1:0]   MCAND,
  input  logic [N-1:0]   MPLIER,
  input  logic [N-1:0]   ADDEND,
  output logic [2*N-1:0] PRODUCT,
  output logic           Finish,
  output logic           Busy
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, step, finalize;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    step     = 1'b0;
    finalize = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ADDR;
      end
      ADDR: begin
        finalize = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        // The edge leaving DONE is also an accept slot, so a held Start
        // yields one result every N+2 cycles.
        if (Start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_add_datapath #(.N(N)) u_datapath (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .step     (step),
    .finalize (finalize),
    .mcand    (MCAND),
    .mplier   (MPLIER),
    .addend   (ADDEND),
    .product  (PRODUCT)
  );

  assign Finish = (state_q == DONE);
  assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_add_reconstructor.sv
// Randomized scoreboard bench for mul_add_reconstructor against an arithmetic model.
module tb_mul_add_reconstructor;

  localparam int N = 5;
  localparam int MAXV = (1 << N) - 1;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           Start = 1'b0;
  logic [N-1:0]   MCAND = '0;
  logic [N-1:0]   MPLIER = '0;
  logic [N-1:0]   ADDEND = '0;
  logic [2*N-1:0] PRODUCT;
  logic           Finish;
  logic           Busy;

  mul_add_reconstructor #(.N(N)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .MCAND   (MCAND),
    .MPLIER  (MPLIER),
    .ADDEND  (ADDEND),
    .PRODUCT (PRODUCT),
    .Finish  (Finish),
    .Busy    (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   edge_n    = 0;
  int   next_free = 0;
  int   held      = 0;
  int   total     = 0;
  int   bad       = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, req);
    end
  endtask

  // Reference model: an operation is accepted at any edge where Start is high
  // and the unit has finished the previous one; result is plain arithmetic.
  initial begin
    forever begin
      @(posedge CLK);
      edge_n = edge_n + 1;
      if (RST) begin
        exp_q.delete();
        next_free = 0;
      end else if (Start && edge_n >= next_free) begin
        exp_q.push_back('{due: edge_n + N + 1,
                          val: int'(MCAND) * int'(MPLIER) + int'(ADDEND)});
        $display("accept @edge %0d: mcand=%0d mplier=%0d addend=%0d", edge_n, MCAND, MPLIER, ADDEND);
        next_free = edge_n + N + 2;
      end
    end
  end

  // Monitor: pops and compares whenever Finish is due, checks the rest every cycle.
  initial begin
    forever begin
      bit fin_exp;
      @(negedge CLK);
      if (RST) held = 0;
      fin_exp = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
      check("finish", Finish, fin_exp);
      if (fin_exp) begin
        held = exp_q[0].val;
        void'(exp_q.pop_front());
        $display("result @edge %0d: PRODUCT=%0d expected %0d", edge_n, PRODUCT, held);
      end
      check("product", PRODUCT, held);
      check("busy", Busy, edge_n < next_free);
    end
  end

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic run_op(input int mc, input int mp, input int ad, input int hold);
    tick();
    MCAND  = N'(mc);
    MPLIER = N'(mp);
    ADDEND = N'(ad);
    Start  = 1'b1;
    repeat (hold) tick();
    Start  = 1'b0;
    MCAND  = N'($urandom);
    MPLIER = N'($urandom);
    ADDEND = N'($urandom);
    repeat (N + 4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    #1;
    check("reset_product", PRODUCT, 0);
    check("reset_busy", Busy, 0);
    check("reset_finish", Finish, 0);
    RST = 1'b0;
    tick();

    run_op(14, 13, 6, 2);
    run_op(5, 30, 2, 1);
    run_op(19, 10, 9, 1);
    run_op(31, 31, 31, 1);
    run_op(17, 0, 4, 1);
    run_op(5, 6, 1, 3);

    // Abort mid-CALC with an asynchronous reset.
    tick();
    MCAND = 10; MPLIER = 24; ADDEND = 0; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_finish", Finish, 0);
    check("abort_product", PRODUCT, 0);
    repeat (2) tick();
    RST = 1'b0;
    run_op(10, 24, 0, 1);

    // Start held continuously while operands churn every cycle.
    tick();
    Start = 1'b1;
    for (int i = 0; i < 22; i++) begin
      MCAND  = N'($urandom);
      MPLIER = N'($urandom);
      ADDEND = N'($urandom);
      tick();
    end
    Start = 1'b0;
    repeat (N + 4) tick();

    // Round trip against divider vectors: divisor*quotient+remainder = dividend.
    for (int i = 0; i < 20; i++) begin
      int dd, dv;
      dd = $urandom_range(MAXV, 0);
      dv = $urandom_range(MAXV, 1);
      run_op(dv, dd / dv, dd % dv, 1);
      check("round_trip", PRODUCT, dd);
    end

    for (int i = 0; i < 30; i++) begin
      run_op($urandom_range(MAXV, 0), $urandom_range(MAXV, 0),
             $urandom_range(MAXV, 0), $urandom_range(3, 1));
    end

    repeat (4) tick();
    check("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
